mag_search_sar: RTL

//  Successive-approximation search controller that drives the y side of an external

---
 rtl/mag_search_sar.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mag_search_sar.sv
// rtl/mag_search_sar.sv - successive-approximation search controller driving a magnitude comparator
//
// Binary-searches a hidden W-bit value presented on the comparator's x side.
// The search is driven through the comparator's y side (guess_o), and the
// comparator's gt/lt/eq verdicts are consumed each cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start_i    begin a search (honoured only in IDLE)
//   guess_o    value presented to comparator y input
//   cmp_gt_i   hidden value above guess
//   cmp_lt_i   hidden value below guess
//   cmp_eq_i   hidden value equals guess
//   busy_o     high while probing
//   done_o     one-cycle pulse when a search ends
//   found_o    hidden value located (held until next start)
//   err_o      comparator inconsistent (held until next start)
//   result_o   located value (held until next start)
//   probes_o   number of probes used (held until next start)
module mag_search_sar #(
    parameter int W = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    output logic [W-1:0]            guess_o,
    input  logic                    cmp_gt_i,
    input  logic                    cmp_lt_i,
    input  logic                    cmp_eq_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    found_o,
    output logic                    err_o,
    output logic [W-1:0]            result_o,
    output logic [$clog2(W+2)-1:0]  probes_o
);
    localparam int PW = $clog2(W + 2);
    localparam logic [W:0] MAXV = (W + 1)'((1 << W) - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PROBE,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [W:0]     lo_q, lo_d;
    logic [W:0]     hi_q, hi_d;
    logic [W-1:0]   guess_q, guess_d;
    logic [W-1:0]   result_q, result_d;
    logic [PW-1:0]  probes_q, probes_d;
    logic           found_q, found_d;
    logic           err_q, err_d;

    logic [W:0]     lo_n, hi_n, sum_n, guess_ext;
    logic           bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            lo_q     <= '0;
            hi_q     <= '0;
            guess_q  <= '0;
            result_q <= '0;
            probes_q <= '0;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            guess_q  <= guess_d;
            result_q <= result_d;
            probes_q <= probes_d;
            found_q  <= found_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        guess_d   = guess_q;
        result_d  = result_q;
        probes_d  = probes_q;
        found_d   = found_q;
        err_d     = err_q;
        guess_ext = {1'b0, guess_q};
        lo_n      = lo_q;
        hi_n      = hi_q;
        bad       = 1'b0;
        sum_n     = '0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    lo_d     = '0;
                    hi_d     = MAXV;
                    guess_d  = W'(MAXV >> 1);
                    probes_d = '0;
                    result_d = '0;
                    found_d  = 1'b0;
                    err_d    = 1'b0;
                    state_d  = S_PROBE;
                end
            end

            S_PROBE: begin
                probes_d = probes_q + PW'(1);
                case ({cmp_gt_i, cmp_lt_i, cmp_eq_i})
                    3'b001: begin
                        result_d = guess_q;
                        found_d  = 1'b1;
                        state_d  = S_DONE;
                    end
                    3'b100: begin
                        lo_n = guess_ext + (W + 1)'(1);
                        bad  = (guess_q == {W{1'b1}});
                    end
                    3'b010: begin
                        hi_n = guess_ext - (W + 1)'(1);
                        bad  = (guess_q == '0);
                    end
                    default: bad = 1'b1;
                endcase

                if (state_d != S_DONE) begin
                    lo_d  = lo_n;
                    hi_d  = hi_n;
                    sum_n = lo_n + hi_n;
                    // A consistent comparator always hits eq by probe W+1, so
                    // running out of probes or crossing bounds means it lied.
                    if (bad || (lo_n > hi_n) || (probes_d == PW'(W + 1))) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        guess_d = W'(sum_n >> 1);
                    end
                end
            end

            S_DONE: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase
    end

    assign guess_o  = guess_q;
    assign busy_o   = (state_q == S_PROBE);
    assign done_o   = (state_q == S_DONE);
    assign found_o  = found_q;
    assign err_o    = err_q;
    assign result_o = result_q;
    assign probes_o = probes_q;
endmodule
